// File: rtl/block_line_sum_gen.sv
// Per-line column sum producer and block-duty phase generator.
// Sums one 64-pixel block column per line and emits the block mean per row.
module block_line_sum_gen #(
  parameter int BLK_COL  = 0,
  parameter int BLK_ROWS = 8,
  parameter int EVAL_CYC = 70
) (
  input  logic        iODCK,
  input  logic        iRST,
  input  logic        iVS,
  input  logic        iDE,
  input  logic [7:0]  iPixel,
  output logic        oV_Duty,
  output logic        oWEA,
  output logic [13:0] oPreLineSum,
  output logic [6:0]  oV_Block_Duty_Count,
  output logic [7:0]  oBlockData,
  output logic        oOverrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_EVAL
  } state_t;

  localparam logic [4:0]  W_COL   = 5'(BLK_COL);
  localparam logic [15:0] EV_LAST = 16'(EVAL_CYC - 1);
  localparam logic [7:0]  ROWS_N  = 8'(BLK_ROWS);

  state_t      r_state;
  logic [10:0] r_hcount;
  logic        r_de_d;
  logic        r_line_ok;
  logic [13:0] r_acc;
  logic [19:0] r_blksum;
  logic [6:0]  r_lidx;
  logic [7:0]  r_rows;
  logic [15:0] r_evcnt;
  logic        r_duty;
  logic        r_wea;
  logic [13:0] r_sum;
  logic [6:0]  r_idx;
  logic [7:0]  r_bdata;
  logic        r_ovr;

  logic        w_start;
  logic        w_in_win;
  logic        w_last;
  logic        w_ok;
  logic        w_take;
  logic [13:0] w_base;
  logic [13:0] w_lsum;
  logic        w_row_end;
  logic        w_rows_done;

  // Window decode, line-qualification and running line sum
  always_comb begin
    w_start     = iDE & ~r_de_d;
    w_in_win    = (r_hcount[10:6] == W_COL);
    w_last      = w_in_win & (r_hcount[5:0] == 6'd63);
    w_ok        = w_start ? (r_state == S_COLLECT) : r_line_ok;
    w_take      = iDE & w_ok & (r_state == S_COLLECT) & w_in_win;
    w_base      = w_start ? 14'd0 : r_acc;
    w_lsum      = w_base + {6'd0, iPixel};
    w_row_end   = r_wea & (r_idx == 7'd63);
    w_rows_done = (r_rows >= ROWS_N);
  end

  // Horizontal pixel position within the current DE run
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      r_hcount <= '0;
      r_de_d   <= 1'b0;
    end else begin
      r_de_d <= iDE;
      if (iVS)
        r_hcount <= '0;
      else if (iDE)
        r_hcount <= r_hcount + 11'd1;
      else
        r_hcount <= '0;
    end
  end

  // Phase FSM with line/block accumulation and registered outputs
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      r_state   <= S_IDLE;
      r_line_ok <= 1'b0;
      r_acc     <= '0;
      r_blksum  <= '0;
      r_lidx    <= '0;
      r_rows    <= '0;
      r_evcnt   <= '0;
      r_duty    <= 1'b0;
      r_wea     <= 1'b0;
      r_sum     <= '0;
      r_idx     <= '0;
      r_bdata   <= '0;
      r_ovr     <= 1'b0;
    end else begin
      r_wea <= 1'b0;
      if (iVS) begin
        r_state   <= S_COLLECT;
        r_duty    <= 1'b1;
        r_line_ok <= 1'b0;
        r_acc     <= '0;
        r_blksum  <= '0;
        r_lidx    <= '0;
        r_rows    <= '0;
        r_evcnt   <= '0;
        r_ovr     <= 1'b0;
      end else begin
        if (w_start)
          r_line_ok <= (r_state == S_COLLECT);
        if (w_start && r_state == S_EVAL)
          r_ovr <= 1'b1;
        if (w_take)
          r_acc <= w_lsum;
        else if (w_start)
          r_acc <= '0;
        if (w_take && w_last) begin
          r_wea    <= 1'b1;
          r_sum    <= w_lsum;
          r_idx    <= r_lidx;
          r_lidx   <= r_lidx + 7'd1;
          r_blksum <= r_blksum + {6'd0, w_lsum};
        end
        unique case (r_state)
          S_IDLE: begin
            r_duty <= 1'b0;
          end
          S_COLLECT: begin
            if (w_row_end) begin
              r_state   <= S_EVAL;
              r_duty    <= 1'b0;
              r_bdata   <= r_blksum[19:12];
              r_blksum  <= '0;
              r_lidx    <= '0;
              r_rows    <= r_rows + 8'd1;
              r_evcnt   <= '0;
              r_line_ok <= 1'b0;
            end
          end
          S_EVAL: begin
            if (r_evcnt == EV_LAST) begin
              r_state <= w_rows_done ? S_IDLE : S_COLLECT;
              r_duty  <= ~w_rows_done;
            end else begin
              r_evcnt <= r_evcnt + 16'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_duty  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oV_Duty             = r_duty;
  assign oWEA                = r_wea;
  assign oPreLineSum         = r_sum;
  assign oV_Block_Duty_Count = r_idx;
  assign oBlockData          = r_bdata;
  assign oOverrun            = r_ovr;

endmodule

// File: tb/tb_block_line_sum_gen.sv
// Scoreboard bench for block_line_sum_gen.
// Stimulus pushes expected writes; a negedge monitor pops and compares.
module tb_block_line_sum_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic        de;
  logic [7:0]  pix;
  logic        duty;
  logic        wea;
  logic [13:0] lsum;
  logic [6:0]  lidx;
  logic [7:0]  bdata;
  logic        ovr;

  always #5 clk = ~clk;

  block_line_sum_gen #(
    .BLK_COL (1),
    .BLK_ROWS(2),
    .EVAL_CYC(70)
  ) dut (
    .iODCK              (clk),
    .iRST               (rst_n),
    .iVS                (vs),
    .iDE                (de),
    .iPixel             (pix),
    .oV_Duty            (duty),
    .oWEA               (wea),
    .oPreLineSum        (lsum),
    .oV_Block_Duty_Count(lidx),
    .oBlockData         (bdata),
    .oOverrun           (ovr)
  );

  typedef struct packed {
    logic [13:0] sum;
    logic [6:0]  idx;
  } wr_t;

  wr_t  exp_w[$];
  int   exp_b[$];
  int   exp_low[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic prev_duty = 1'b0;
  logic prev63    = 1'b0;
  bit   in_low    = 1'b0;
  int   low_cnt   = 0;
  wr_t  e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_duty = 1'b0;
      prev63    = 1'b0;
      in_low    = 1'b0;
    end else begin
      if (wea) begin
        chk("wea_duty", int'(duty), 1);
        if (exp_w.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_wea: got idx %0d sum %0d expected none",
                   lidx, lsum);
        end else begin
          e = exp_w.pop_front();
          chk("line_sum", int'(lsum), int'(e.sum));
          chk("line_idx", int'(lidx), int'(e.idx));
        end
      end
      if (prev_duty && !duty) begin
        chk("fall_after_63", int'(prev63), 1);
        if (exp_b.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_fall: got bdata %0d expected none", bdata);
        end else begin
          chk("block_data", int'(bdata), exp_b.pop_front());
        end
        in_low  = 1'b1;
        low_cnt = 1;
      end else if (!prev_duty && !duty && in_low) begin
        low_cnt++;
      end else if (!prev_duty && duty && in_low) begin
        in_low = 1'b0;
        if (exp_low.size() > 0)
          chk("eval_len", low_cnt, exp_low.pop_front());
      end
      prev_duty = duty;
      prev63    = wea && (lidx == 7'd63);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int len, input bit ff, input int blank,
                      input int vs_at);
    for (int i = 0; i < len; i++) begin
      de  = 1'b1;
      pix = ff ? 8'hFF : i[7:0];
      vs  = (i == vs_at);
      tick();
    end
    de  = 1'b0;
    pix = 8'h00;
    vs  = 1'b0;
    repeat (blank) tick();
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic push_w(input int s, input int idx);
    wr_t w;
    w.sum = 14'(s);
    w.idx = 7'(idx);
    exp_w.push_back(w);
  endtask

  initial begin
    int hi;
    int t;
    rst_n = 1'b0;
    vs    = 1'b0;
    de    = 1'b0;
    pix   = 8'h00;
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("rst_duty", int'(duty), 0);
    chk("rst_wea", int'(wea), 0);
    chk("rst_sum", int'(lsum), 0);
    chk("rst_idx", int'(lidx), 0);
    chk("rst_bdata", int'(bdata), 0);
    chk("rst_ovr", int'(ovr), 0);
    rst_n = 1'b1;
    tick();

    // reset asserted mid-line at hcount 30
    vs_pulse();
    chk("duty_after_vs", int'(duty), 1);
    for (int i = 0; i < 30; i++) begin
      de  = 1'b1;
      pix = 8'hFF;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", int'(duty), 0);
    chk("mid_rst_wea", int'(wea), 0);
    chk("mid_rst_ovr", int'(ovr), 0);
    de  = 1'b0;
    pix = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    line(128, 1'b1, 100, -1);
    chk("idle_after_rst", int'(duty), 0);

    // row 0: all-0xFF lines, last line followed by short blanking
    vs_pulse();
    exp_low.push_back(70);
    exp_b.push_back(255);
    for (int l = 0; l < 64; l++) begin
      push_w(16320, l);
      line(128, 1'b1, (l == 63) ? 10 : 100, -1);
    end
    // this line starts 10 cycles into evaluation and must be ignored
    line(128, 1'b0, 100, -1);
    chk("overrun_set", int'(ovr), 1);

    // row 1: ramp pixels with a short line at index 5
    exp_b.push_back(95);
    for (int l = 0; l < 64; l++) begin
      if (l == 5)
        line(100, 1'b0, 100, -1);
      push_w(6112, l);
      line(128, 1'b0, 100, -1);
    end
    chk("overrun_held", int'(ovr), 1);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (duty)
        hi++;
    end
    chk("idle_after_rows", hi, 0);
    line(128, 1'b0, 100, -1);
    chk("idle_line_duty", int'(duty), 0);
    chk("bdata_row1", int'(bdata), 95);

    // restart frame, then iVS in the middle of line index 20
    vs_pulse();
    chk("overrun_clr", int'(ovr), 0);
    for (int l = 0; l < 20; l++) begin
      push_w(6112, l);
      line(128, 1'b0, 100, -1);
    end
    line(128, 1'b0, 100, 80);
    chk("bdata_kept", int'(bdata), 95);
    chk("duty_after_vs2", int'(duty), 1);
    for (int l = 0; l < 3; l++) begin
      push_w(6112, l);
      line(128, 1'b0, 100, -1);
    end

    t = 0;
    while ((exp_w.size() != 0 || exp_b.size() != 0) && t < 1000) begin
      tick();
      t++;
    end
    chk("exp_w_drained", exp_w.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);
    chk("exp_low_drained", exp_low.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/block_line_sum_gen.md
Name: block_line_sum_gen

Overview:
- Producer side of the per-line-sum / block-duty interface. Takes the active-video luma stream and sums the 64 pixels of one selected block column on each line.
- Writes each 14-bit line sum, with its line index, using a one-cycle write strobe.
- Drives the block-duty phase signal. After 64 lines it drops duty for a fixed evaluation window and presents the 8-bit block mean (iBlockData source) to the downstream variance/enhancement stage.

Parameters:
BLK_COL, 0, block column index; summed pixels are horizontal positions BLK_COL*64 .. BLK_COL*64+63
BLK_ROWS, 8, block rows per frame; after this many rows the block idles until next iVS
EVAL_CYC, 70, cycles oV_Duty is held low per block row (must be >= 67 for the consumer)

Ports:
iODCK  in  1  pixel clock
iRST  in  1  reset, asynchronous, active-low
iVS  in  1  frame-start pulse, one cycle, sampled on iODCK
iDE  in  1  pixel valid; a contiguous high run is one line
iPixel  in  8  luma pixel, valid when iDE=1
oV_Duty  out  1  1 = collect phase (line writes allowed), 0 = evaluation phase
oWEA  out  1  one-cycle line-sum write strobe
oPreLineSum  out  14  line sum, valid with oWEA
oV_Block_Duty_Count  out  7  line index 0-63 within the block row, valid with oWEA
oBlockData  out  8  block mean, valid and held from the oV_Duty fall until the next fall
oOverrun  out  1  sticky: line started during evaluation; cleared by iVS

Behaviour:
- Reset (iRST=0, async):
  - State IDLE; all counters and accumulators cleared.
  - oV_Duty=0, oWEA=0, oPreLineSum=0, oV_Block_Duty_Count=0, oBlockData=0, oOverrun=0.
- States:
  - IDLE: oV_Duty=0; iVS -> COLLECT.
  - COLLECT: oV_Duty=1.
  - EVAL: oV_Duty=0 for exactly EVAL_CYC cycles, then COLLECT, or IDLE once BLK_ROWS rows are done.
- iVS in any state:
  - Enter COLLECT next cycle; clear hcount, line index, row count, accumulators and oOverrun.
  - Any partial line is discarded with no oWEA.
  - oBlockData is kept.
- Horizontal counter hcount (11-bit):
  - Increments on each iDE=1 cycle.
  - Cleared on the iDE falling edge (first iDE=0 cycle after iDE=1).
- Line accumulator (14-bit):
  - In COLLECT, adds iPixel when iDE=1 and hcount is within the column window.
  - Cleared at each line start. Max 64*255=16320, so no overflow or saturation.
- Line write timing:
  - When the pixel at hcount = BLK_COL*64+63 is sampled, the next cycle drives oWEA=1.
  - oPreLineSum = full 64-pixel sum, including that last pixel.
  - oV_Block_Duty_Count = current line index.
  - The line index then increments.
- Short lines: iDE falls before the window ends -> no oWEA, line index unchanged, accumulator discarded.
- Block sum (20-bit) = sum of the 64 line sums written this row.
- Row end:
  - The cycle after the oWEA with index 63: oV_Duty=0, state EVAL, oBlockData = blocksum[19:12] (floor of /4096).
  - Block sum and line index are cleared; row count increments.
- oWEA is never asserted while oV_Duty=0.
- oV_Duty is always 1 during an oWEA cycle.
- Line during EVAL: if iDE rises in EVAL, that whole line is ignored even if EVAL ends mid-line, and oOverrun is set.
- Latency: last column pixel -> oWEA is 1 cycle; oWEA(63) -> oV_Duty fall and oBlockData update is 1 cycle.

Test Plan:
- Reset mid-line (iRST low during COLLECT, hcount=30) -> all outputs 0 immediately, state IDLE; after release, no oWEA until iVS.
- BLK_COL=0, iVS, 64 lines of 128 pixels all 0xFF, 100-cycle blanking -> 64 oWEA pulses with oPreLineSum=16320 and indices 0..63. Cycle after index 63: oV_Duty=0 and oBlockData=0xFF; oV_Duty stays low exactly 70 cycles.
- BLK_COL=1, pixels = hcount[7:0] -> each oPreLineSum = sum(64..127) = 6112; oBlockData = (64*6112)>>12 = 95.
- Short line: line 5 DE length 100 with BLK_COL=1 -> no oWEA for it; next full line written with index 5.
- Line started 10 cycles into EVAL -> not summed, oOverrun=1 and held until next iVS; next line written with index 0.
- iVS at line index 20 of row 2 -> line index restarts at 0, no partial-line write, oBlockData unchanged. With BLK_ROWS=2, after 2 full rows state is IDLE and oV_Duty stays 0.
